// File: rtl/arc4_prga.sv
`timescale 1ns/1ps
// arc4_prga: ARC4 keystream stage that permutes S and turns the length-prefixed CT buffer into the PT buffer.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   en / rdy              start request / idle and ready to accept en
//   s_addr, s_rddata      S-memory address and read data (1-cycle read latency)
//   s_wrdata, s_wren      S-memory write data and write enable
//   ct_addr, ct_rddata    CT-memory address and read data (1-cycle read latency)
//   pt_addr, pt_wrdata    PT-memory address and write data
//   pt_wren               PT-memory write enable
module arc4_prga (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren
);
    typedef enum logic [3:0] {IDLE, LEN, LENW, RI, LI, RJ, LJ, WI, WJ, RP, LP} state_t;
    state_t state, state_nx;
    logic [7:0] i, j, k, mlen, si, sj;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            i     <= 8'd0;
            j     <= 8'd0;
            k     <= 8'd0;
            mlen  <= 8'd0;
            si    <= 8'd0;
            sj    <= 8'd0;
        end else begin
            state <= state_nx;
            case (state)
                LENW: begin
                    mlen <= ct_rddata;
                    i    <= 8'd0;
                    j    <= 8'd0;
                    k    <= 8'd1;
                end
                RI: i <= i + 8'd1;
                LI: begin
                    si <= s_rddata;
                    j  <= j + s_rddata;
                end
                LJ: sj <= s_rddata;
                LP: if (k != mlen) k <= k + 8'd1;
                default: ;
            endcase
        end
    end
    // All strobes are plain decodes of the current state; read data returns in the following state.
    always_comb begin
        state_nx  = state;
        rdy       = 1'b0;
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (state)
            IDLE: begin
                rdy      = 1'b1;
                state_nx = en ? LEN : IDLE;
            end
            LEN: state_nx = LENW;
            LENW: begin
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                state_nx  = (ct_rddata == 8'd0) ? IDLE : RI;
            end
            RI: begin
                s_addr   = i + 8'd1;
                state_nx = LI;
            end
            LI: state_nx = RJ;
            RJ: begin
                s_addr   = j;
                state_nx = LJ;
            end
            LJ: state_nx = WI;
            // When i==j both writes store the same byte, leaving S unchanged as required.
            WI: begin
                s_addr   = i;
                s_wrdata = sj;
                s_wren   = 1'b1;
                state_nx = WJ;
            end
            WJ: begin
                s_addr   = j;
                s_wrdata = si;
                s_wren   = 1'b1;
                state_nx = RP;
            end
            // Pad read sees the post-swap S since the WJ write has already committed.
            RP: begin
                s_addr   = si + sj;
                ct_addr  = k;
                state_nx = LP;
            end
            LP: begin
                pt_addr   = k;
                pt_wrdata = s_rddata ^ ct_rddata;
                pt_wren   = 1'b1;
                state_nx  = (k == mlen) ? IDLE : RI;
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_arc4_prga.sv
`timescale 1ns/1ps
// tb_arc4_prga: directed self-checking bench for arc4_prga with behavioural S/CT/PT memories.
module tb_arc4_prga;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy, s_wren, pt_wren;
    logic [7:0] s_addr, s_wrdata, ct_addr, pt_addr, pt_wrdata;
    logic [7:0] s_q, ct_q;
    logic [7:0] s_mem [256];
    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    logic [7:0] exp_pt [256];
    logic [7:0] exp_s [256];
    logic       s_init = 1'b0;
    logic       pt_clr = 1'b0;
    int s_wr_cnt = 0, pt_wr_cnt = 0, oob_cnt = 0;
    int compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    arc4_prga dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_q), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_q),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren)
    );

    always @(posedge clk) begin
        s_q  <= s_mem[s_addr];
        ct_q <= ct_mem[ct_addr];
        if (s_init) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
            s_wr_cnt <= s_wr_cnt + 1;
        end
        if (pt_clr) begin
            for (int x = 0; x < 256; x++) pt_mem[x] <= 8'hEE;
        end else if (pt_wren) begin
            pt_mem[pt_addr] <= pt_wrdata;
            pt_wr_cnt <= pt_wr_cnt + 1;
            if (pt_addr > ct_mem[0]) oob_cnt <= oob_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic init_mem();
        @(negedge clk);
        s_init = 1'b1;
        pt_clr = 1'b1;
        @(negedge clk);
        s_init = 1'b0;
        pt_clr = 1'b0;
    endtask

    task automatic wait_low(output int n);
        n = 0;
        while (rdy === 1'b0 && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic start_run(output int n);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        wait_low(n);
    endtask

    task automatic check_small(input string tag, input int n, input int s0, input int p0);
        check({tag, "_rdy_low"}, n, 18);
        check({tag, "_pt0"}, pt_mem[0], 8'h02);
        check({tag, "_pt1"}, pt_mem[1], 8'h43);
        check({tag, "_pt2"}, pt_mem[2], 8'h47);
        check({tag, "_pt3_untouched"}, pt_mem[3], 8'hEE);
        check({tag, "_s_writes"}, s_wr_cnt - s0, 4);
        check({tag, "_pt_writes"}, pt_wr_cnt - p0, 3);
        for (int x = 0; x < 256; x++)
            check($sformatf("%s_s[%0d]", tag, x), s_mem[x], (x == 2) ? 3 : (x == 3) ? 2 : x);
    endtask

    task automatic model();
        logic [7:0] s [256];
        logic [7:0] i, j, t, idx;
        for (int x = 0; x < 256; x++) s[x] = 8'(x);
        i = 0;
        j = 0;
        exp_pt[0] = ct_mem[0];
        for (int k = 1; k <= int'(ct_mem[0]); k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i];
            s[i] = s[j];
            s[j] = t;
            idx = s[i] + s[j];
            exp_pt[k] = s[idx] ^ ct_mem[k];
        end
        for (int x = 0; x < 256; x++) exp_s[x] = s[x];
    endtask

    initial begin
        int n, n2, h, s0, p0, seen [256];
        bit found;
        for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", rdy, 1);
        check("rst_s_wren", s_wren, 0);
        check("rst_pt_wren", pt_wren, 0);
        check("rst_s_addr", s_addr, 0);
        check("rst_ct_addr", ct_addr, 0);
        check("rst_pt_addr", pt_addr, 0);
        rst_n = 1'b1;
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        repeat (10) @(negedge clk);
        check("idle_rdy", rdy, 1);
        check("idle_s_writes", s_wr_cnt - s0, 0);
        check("idle_pt_writes", pt_wr_cnt - p0, 0);
        // mlen = 0
        init_mem();
        ct_mem[0] = 8'h00;
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        start_run(n);
        check("m0_rdy_low", n, 2);
        check("m0_pt0", pt_mem[0], 8'h00);
        check("m0_s_writes", s_wr_cnt - s0, 0);
        check("m0_pt_writes", pt_wr_cnt - p0, 1);
        // Identity S, two bytes
        init_mem();
        ct_mem[0] = 8'h02;
        ct_mem[1] = 8'h41;
        ct_mem[2] = 8'h42;
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        start_run(n);
        check_small("id", n, s0, p0);
        // Reset during WI of byte 2 (WI of byte 2 writes address i=2)
        init_mem();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (s_wren === 1'b1 && s_addr === 8'd2) found = 1'b1;
            else @(negedge clk);
        end
        check("mid_found_wi", found, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rdy", rdy, 1);
        check("mid_s_wren", s_wren, 0);
        check("mid_pt_wren", pt_wren, 0);
        rst_n = 1'b1;
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        repeat (10) @(negedge clk);
        check("mid_s_writes", s_wr_cnt - s0, 0);
        check("mid_pt_writes", pt_wr_cnt - p0, 0);
        check("mid_rdy_after", rdy, 1);
        init_mem();
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        start_run(n);
        check_small("rerun", n, s0, p0);
        // en held high across a run: restart only at the first rdy=1 cycle
        init_mem();
        ct_mem[0] = 8'h01;
        ct_mem[1] = 8'h10;
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        wait_low(n);
        h = 0;
        while (rdy === 1'b1 && h < 20) begin
            h++;
            @(negedge clk);
        end
        wait_low(n2);
        en = 1'b0;
        check("hold_low1", n, 10);
        check("hold_high", h, 1);
        check("hold_low2", n2, 10);
        repeat (5) @(negedge clk);
        check("hold_rdy_after", rdy, 1);
        check("hold_pt_writes", pt_wr_cnt - p0, 4);
        check("hold_s_writes", s_wr_cnt - s0, 4);
        check("hold_pt1", pt_mem[1], 8'h12);
        // mlen = 255 against the reference model
        init_mem();
        ct_mem[0] = 8'hFF;
        for (int x = 1; x < 256; x++) ct_mem[x] = 8'h00;
        model();
        s0 = s_wr_cnt;
        p0 = pt_wr_cnt;
        start_run(n);
        check("big_rdy_low", n, 2042);
        check("big_s_writes", s_wr_cnt - s0, 510);
        check("big_pt_writes", pt_wr_cnt - p0, 256);
        check("big_pt0", pt_mem[0], 8'hFF);
        for (int x = 1; x < 256; x++) check($sformatf("big_pt[%0d]", x), pt_mem[x], exp_pt[x]);
        for (int x = 0; x < 256; x++) seen[x] = 0;
        for (int x = 0; x < 256; x++) begin
            check($sformatf("big_s[%0d]", x), s_mem[x], exp_s[x]);
            if (!$isunknown(s_mem[x])) seen[s_mem[x]]++;
        end
        for (int x = 0; x < 256; x++) check($sformatf("big_perm[%0d]", x), seen[x], 1);
        check("oob_pt_writes", oob_cnt, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
